trivium_host_driver: RTL and testbench

Host-side driver for the Trivium core's serial key/IV/data interface. It latches an 80-bit key and 80-bit IV and shifts them out serially, key first and LSB first. It then handles load and warm-up, serialises host bytes into the core, and reassembles the core's serial cipher output into bytes. It sits between a byte-wide host bus and the core's `dat_i`/`get_dat_i`/`ld_keys_i`/`end_i`/`dat_o`/`ready_o` pins.

---
 rtl/trivium_host_driver.sv | 252 +++++++++++++++++++++++++
 tb/tb_trivium_host_driver.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_host_driver.sv
// ---------------------------------------------------------------------------
// trivium_host_driver
//
// Host-side driver for a Trivium core with a serial key/IV/data interface.
// A session latches an 80-bit key and IV, shifts them into the core
// (key first, LSB first), pulses the load strobe, waits for the core to
// finish warm-up, then streams host bytes into the core one bit per cycle.
// The core's serial cipher output is reassembled into bytes.
//
// Parameters
//   OUT_LAT      cycles from a data bit on core_dat_o to its cipher bit on
//                core_dat_i (0..3)
//   RDY_TIMEOUT  WAIT_RDY cycles allowed before err_o is raised
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                begin a session (ignored while busy_o)
//   key_i, iv_i            80-bit key and IV, latched with start_i
//   pdat_i/pvalid_i/plast_i/pready_o  plaintext byte stream (valid/ready)
//   cbyte_o, cvalid_o      cipher byte and its one-cycle strobe
//   core_dat_o/core_get_o/core_ld_o/core_end_o  drive the core's
//                          dat_i/get_dat_i/ld_keys_i/end_i
//   core_dat_i, core_rdy_i the core's dat_o and ready_o
//   busy_o, done_o, err_o  session in progress, end pulse, sticky timeout
// ---------------------------------------------------------------------------
module trivium_host_driver #(
  parameter int OUT_LAT     = 1,
  parameter int RDY_TIMEOUT = 2047
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  input  logic [7:0]  pdat_i,
  input  logic        pvalid_i,
  input  logic        plast_i,
  output logic        pready_o,
  output logic [7:0]  cbyte_o,
  output logic        cvalid_o,
  output logic        core_dat_o,
  output logic        core_get_o,
  output logic        core_ld_o,
  output logic        core_end_o,
  input  logic        core_dat_i,
  input  logic        core_rdy_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int          WCW      = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RDY_TIMEOUT - 1);
  localparam logic [7:0]  LAST_BIT = 8'd159;

  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_SHIFT, S_WAIT_RDY, S_PRIME, S_STREAM, S_DRAIN, S_CLOSE
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [159:0]   r_sr;        // {iv, key}, bit 0 is the next bit on the wire
  logic [7:0]     r_cnt;       // SHIFT bit index 0..159
  logic [WCW-1:0] r_wait_cnt;  // WAIT_RDY cycles elapsed
  logic           r_rdy_seen;  // core reported ready, now only waiting on host
  logic [7:0]     r_byte;      // byte being streamed
  logic [2:0]     r_bit;       // bit index within r_byte
  logic           r_last;      // r_byte is the final byte of the stream
  logic [7:0]     r_asm;       // cipher byte assembler, fills from the MSB end
  logic [2:0]     r_cap_cnt;   // cipher bits captured in r_asm
  logic [7:0]     r_cbyte;
  logic           r_cvalid;
  logic           r_err;

  logic           w_rdy;
  logic           w_timeout;
  logic           w_more;
  logic           w_tag;
  logic           w_cap;
  logic           w_dl_busy;

  assign w_rdy     = core_rdy_i | r_rdy_seen;
  assign w_timeout = (r_wait_cnt == WAIT_LAST);
  assign w_more    = ~r_last & pvalid_i;
  // Only STREAM cycles present a plaintext bit the core will encrypt.
  assign w_tag     = (r_state == S_STREAM);

  // Delay line aligning data-bit tags with the core's output latency.
  generate
    if (OUT_LAT == 0) begin : g_no_lat
      assign w_cap     = w_tag;
      assign w_dl_busy = 1'b0;
    end else begin : g_lat
      logic [OUT_LAT-1:0] r_dl;
      always_ff @(posedge clk_i) begin
        if (rst_i) r_dl <= '0;
        else       r_dl <= (r_dl << 1) | OUT_LAT'(w_tag);
      end
      assign w_cap     = r_dl[OUT_LAT-1];
      assign w_dl_busy = |r_dl;
    end
  endgenerate

  // ---------------- FSM: state register ----------------
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start_i) w_next = S_KICK;
      S_KICK:     w_next = S_SHIFT;
      S_SHIFT:    if (r_cnt == LAST_BIT) w_next = S_WAIT_RDY;
      S_WAIT_RDY: begin
        // Ready takes priority over a timeout reached in the same cycle.
        if (w_rdy) begin
          if (pvalid_i) w_next = S_PRIME;
        end else if (w_timeout) begin
          w_next = S_CLOSE;
        end
      end
      S_PRIME:    w_next = S_STREAM;
      S_STREAM:   if ((r_bit == 3'd7) && !w_more) w_next = S_DRAIN;
      S_DRAIN: begin
        // Hold until every in-flight cipher bit has been captured.
        if (!w_dl_busy) begin
          if (r_last)        w_next = S_CLOSE;
          else if (pvalid_i) w_next = S_PRIME;
        end
      end
      S_CLOSE:    w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pready_o   = 1'b0;
    core_dat_o = 1'b0;
    core_get_o = 1'b0;
    core_ld_o  = 1'b0;
    core_end_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (r_state)
      S_IDLE:  busy_o = 1'b0;
      S_KICK:  core_get_o = 1'b1;
      S_SHIFT: begin
        core_dat_o = r_sr[0];
        core_ld_o  = (r_cnt == LAST_BIT);
      end
      S_PRIME: begin
        // The core spends this cycle leaving WAIT; no bit is consumed.
        pready_o   = 1'b1;
        core_get_o = 1'b1;
      end
      S_STREAM: begin
        core_get_o = 1'b1;
        core_dat_o = r_byte[r_bit];
        pready_o   = (r_bit == 3'd7) && w_more;
      end
      S_CLOSE: begin
        core_end_o = 1'b1;
        done_o     = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the 160-bit key/IV register is cleared on reset as well, so no
      // key material from an abandoned session stays in the block.
      r_sr       <= '0;
      r_cnt      <= '0;
      r_wait_cnt <= '0;
      r_rdy_seen <= 1'b0;
      r_byte     <= '0;
      r_bit      <= '0;
      r_last     <= 1'b0;
      r_asm      <= '0;
      r_cap_cnt  <= '0;
      r_cbyte    <= '0;
      r_cvalid   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_sr       <= {iv_i, key_i};
            r_err      <= 1'b0;
            r_rdy_seen <= 1'b0;
            r_last     <= 1'b0;
            r_asm      <= '0;
            r_cap_cnt  <= '0;
          end
        end
        S_KICK: r_cnt <= '0;
        S_SHIFT: begin
          r_sr       <= r_sr >> 1;
          r_cnt      <= r_cnt + 8'd1;
          r_wait_cnt <= '0;
        end
        S_WAIT_RDY: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (core_rdy_i)            r_rdy_seen <= 1'b1;
          if (!w_rdy && w_timeout)   r_err      <= 1'b1;
        end
        S_PRIME: begin
          r_byte <= pdat_i;
          r_last <= plast_i;
          r_bit  <= '0;
        end
        S_STREAM: begin
          r_bit <= r_bit + 3'd1;
          if ((r_bit == 3'd7) && w_more) begin
            r_byte <= pdat_i;
            r_last <= plast_i;
          end
        end
        default: ;
      endcase

      // Cipher bits arrive LSB first; shifting right leaves the first bit in
      // position 0 once eight bits are in.
      if (w_cap) begin
        r_asm     <= {core_dat_i, r_asm[7:1]};
        r_cap_cnt <= r_cap_cnt + 3'd1;
        if (r_cap_cnt == 3'd7) begin
          r_cbyte  <= {core_dat_i, r_asm[7:1]};
          r_cvalid <= 1'b1;
        end
      end
    end
  end

  assign cbyte_o  = r_cbyte;
  assign cvalid_o = r_cvalid;
  assign err_o    = r_err;

endmodule

// File: tb/tb_trivium_host_driver.sv
// ---------------------------------------------------------------------------
// tb_trivium_host_driver
//
// Directed bench for trivium_host_driver. The core is modelled as an echo:
// core_dat_i is core_dat_o delayed by one cycle (OUT_LAT = 1), so every
// cipher byte equals the plaintext byte that produced it.
// ---------------------------------------------------------------------------
module tb_trivium_host_driver;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [79:0] key_i;
  logic [79:0] iv_i;
  logic [7:0]  pdat_i;
  logic        pvalid_i;
  logic        plast_i;
  logic        pready_o;
  logic [7:0]  cbyte_o;
  logic        cvalid_o;
  logic        core_dat_o;
  logic        core_get_o;
  logic        core_ld_o;
  logic        core_end_o;
  logic        core_dat_i;
  logic        core_rdy_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  localparam logic [79:0] KEY = 80'd1;
  localparam logic [79:0] IV  = 80'h8000_0000_0000_0000_0000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Echo core with one cycle of output latency.
  logic echo_q = 1'b0;
  always @(posedge clk) echo_q <= core_dat_o;
  assign core_dat_i = echo_q;

  trivium_host_driver #(.OUT_LAT(1), .RDY_TIMEOUT(2047)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .key_i      (key_i),
    .iv_i       (iv_i),
    .pdat_i     (pdat_i),
    .pvalid_i   (pvalid_i),
    .plast_i    (plast_i),
    .pready_o   (pready_o),
    .cbyte_o    (cbyte_o),
    .cvalid_o   (cvalid_o),
    .core_dat_o (core_dat_o),
    .core_get_o (core_get_o),
    .core_ld_o  (core_ld_o),
    .core_end_o (core_end_o),
    .core_dat_i (core_dat_i),
    .core_rdy_i (core_rdy_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  // Results of the most recent run_stream call.
  logic [7:0] got[$];
  int  get_cnt, get_runs, hs_cnt, first_get, first_cv;
  bit  done_seen, end_at_done, busy_after;

  // Inputs are driven 1 ns after the rising edge, outputs sampled at 2 ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    pvalid_i = 1'b0; plast_i = 1'b0; core_rdy_i = 1'b0; start_i = 1'b0;
    #1;
  endtask

  function automatic logic [16:0] all_outs();
    return {busy_o, done_o, err_o, cvalid_o, cbyte_o, pready_o,
            core_dat_o, core_get_o, core_ld_o, core_end_o};
  endfunction

  // Starts a session with KEY/IV and checks the KICK and SHIFT phases.
  // Returns at the sample point of the load cycle (SHIFT bit 159).
  task automatic do_load(input bit mid_start);
    int bad_dat = 0, bad_ld = 0, bad_busy = 0;
    tick(); key_i = KEY; iv_i = IV; start_i = 1'b1; #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL start_cycle_busy: got %b expected 0", busy_o);
    end
    tick(); start_i = 1'b0; key_i = '0; iv_i = '0; #1;
    checks++;
    if ({busy_o, core_get_o, core_dat_o, core_ld_o} !== 4'b1100) begin
      errors++;
      $display("FAIL kick_outputs: busy/get/dat/ld got %b expected 1100",
               {busy_o, core_get_o, core_dat_o, core_ld_o});
    end
    for (int j = 0; j < 160; j++) begin
      tick();
      if (mid_start && j == 50) begin
        start_i = 1'b1; key_i = '1; iv_i = '1;
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (core_dat_o !== ((j == 0) || (j == 159))) bad_dat++;
      if (core_ld_o  !== (j == 159))               bad_ld++;
      if (busy_o !== 1'b1 || core_get_o !== 1'b0)  bad_busy++;
    end
    start_i = 1'b0;
    checks++;
    if (bad_dat !== 0) begin
      errors++; $display("FAIL shift_dat: %0d wrong cycles, expected 0", bad_dat);
    end
    checks++;
    if (bad_ld !== 0) begin
      errors++; $display("FAIL shift_ld: %0d wrong cycles, expected 0", bad_ld);
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++; $display("FAIL shift_busy: %0d wrong cycles, expected 0", bad_busy);
    end
  endtask

  // From the load-cycle sample point: assert core_rdy_i rdy_delay cycles
  // later, feed nbytes bytes (pvalid_i low for gap cycles after each
  // handshake) and record what the DUT does until done_o.
  task automatic run_stream(input int rdy_delay, input int nbytes,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int gap);
    logic [7:0] bytes[3];
    int  idx = 0, gap_left = 0;
    bit  prev_get = 1'b0, hs;
    bytes = '{b0, b1, b2};
    got.delete();
    get_cnt = 0; get_runs = 0; hs_cnt = 0; first_get = -1; first_cv = -1;
    done_seen = 1'b0; end_at_done = 1'b0; busy_after = 1'b1;
    for (int k = 1; k < rdy_delay; k++) tick();
    tick();
    pdat_i = bytes[0]; plast_i = (nbytes == 1); pvalid_i = 1'b1; core_rdy_i = 1'b1;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      #1;
      if (core_get_o) begin
        get_cnt++;
        if (!prev_get) get_runs++;
        if (first_get < 0) first_get = cyc;
      end
      prev_get = core_get_o;
      if (cvalid_o) begin
        got.push_back(cbyte_o);
        if (first_cv < 0) first_cv = cyc;
      end
      if (done_o) begin
        done_seen = 1'b1; end_at_done = core_end_o;
      end
      hs = pvalid_i && pready_o;
      if (hs) hs_cnt++;
      tick();
      if (done_seen) begin
        core_rdy_i = 1'b0; #1; busy_after = busy_o;
      end else if (hs) begin
        idx++;
        if (idx < nbytes && gap == 0) begin
          pdat_i = bytes[idx]; plast_i = (idx == nbytes - 1);
        end else begin
          pvalid_i = 1'b0; plast_i = 1'b0; gap_left = (idx < nbytes) ? gap : 0;
        end
      end else if (!pvalid_i && gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) begin
          pdat_i = bytes[idx]; plast_i = (idx == nbytes - 1); pvalid_i = 1'b1;
        end
      end
    end
    checks++;
    if (done_seen !== 1'b1) begin
      errors++; $display("FAIL stream_done: no done_o within 400 cycles");
    end
  endtask

  task automatic check_bytes(input string name, input int n,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
    logic [7:0] exp_b[3];
    logic [7:0] act;
    exp_b = '{e0, e1, e2};
    checks++;
    if (got.size() !== n) begin
      errors++; $display("FAIL %s_count: got %0d cvalid pulses expected %0d", name, got.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp_b[i]) begin
        errors++; $display("FAIL %s_byte%0d: got %h expected %h", name, i, act, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; key_i = '0; iv_i = '0;
    pdat_i = '0; pvalid_i = 1'b1; plast_i = 1'b0; core_rdy_i = 1'b0;
    tick(); tick(); #1;
    checks++;
    if (all_outs() !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 00000", all_outs());
    end
    rst_i = 1'b0; pvalid_i = 1'b0;
  endtask

  task automatic test_start_ignored();
    do_load(1'b1);
    pulse_reset();
  endtask

  task automatic test_back_to_back();
    do_load(1'b0);
    run_stream(1153, 3, 8'hA5, 8'h3C, 8'hFF, 0);
    checks++;
    if (get_cnt !== 25) begin
      errors++; $display("FAIL b2b_get_cycles: got %0d expected 25", get_cnt);
    end
    checks++;
    if (get_runs !== 1) begin
      errors++; $display("FAIL b2b_get_runs: got %0d expected 1", get_runs);
    end
    checks++;
    if (hs_cnt !== 3) begin
      errors++; $display("FAIL b2b_accepts: got %0d expected 3", hs_cnt);
    end
    checks++;
    if (first_cv - first_get !== 10) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 10", first_cv - first_get);
    end
    check_bytes("b2b", 3, 8'hA5, 8'h3C, 8'hFF);
    checks++;
    if ({end_at_done, busy_after} !== 2'b10) begin
      errors++; $display("FAIL b2b_close: end/busy_after got %b expected 10", {end_at_done, busy_after});
    end
  endtask

  task automatic test_gap();
    do_load(1'b0);
    // pvalid_i stays low 5 cycles beyond the first byte's 8 stream cycles.
    run_stream(1, 2, 8'h5A, 8'hC3, 8'h00, 13);
    checks++;
    if (get_cnt !== 18) begin
      errors++; $display("FAIL gap_get_cycles: got %0d expected 18", get_cnt);
    end
    checks++;
    if (get_runs !== 2) begin
      errors++; $display("FAIL gap_get_runs: got %0d expected 2", get_runs);
    end
    check_bytes("gap", 2, 8'h5A, 8'hC3, 8'h00);
    checks++;
    if ({end_at_done, busy_after} !== 2'b10) begin
      errors++; $display("FAIL gap_close: end/busy_after got %b expected 10", {end_at_done, busy_after});
    end
  endtask

  task automatic test_timeout();
    int  err_cyc = -1;
    bit  done_at = 1'b0;
    do_load(1'b0);
    pvalid_i = 1'b0; core_rdy_i = 1'b0;
    for (int k = 1; k <= 2100 && err_cyc < 0; k++) begin
      tick(); #1;
      if (err_o) begin
        err_cyc = k; done_at = done_o & core_end_o;
      end
    end
    checks++;
    if (err_cyc !== 2048) begin
      errors++; $display("FAIL timeout_cycle: err_o after %0d cycles expected 2048", err_cyc);
    end
    checks++;
    if (done_at !== 1'b1) begin
      errors++; $display("FAIL timeout_close: done&end got %b expected 1", done_at);
    end
    tick(); #1;
    checks++;
    if ({busy_o, err_o} !== 2'b01) begin
      errors++; $display("FAIL timeout_idle: busy/err got %b expected 01", {busy_o, err_o});
    end
    tick(); start_i = 1'b1; key_i = KEY; iv_i = IV;
    tick(); start_i = 1'b0; #1;
    checks++;
    if ({busy_o, err_o} !== 2'b10) begin
      errors++; $display("FAIL restart_clears_err: busy/err got %b expected 10", {busy_o, err_o});
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_stream();
    int gets = 0, bad = 0;
    do_load(1'b0);
    tick(); pdat_i = 8'h96; plast_i = 1'b0; pvalid_i = 1'b1; core_rdy_i = 1'b1;
    for (int k = 0; k < 30 && gets < 5; k++) begin
      #1;
      if (core_get_o) gets++;
      tick();
    end
    rst_i = 1'b1;
    tick(); rst_i = 1'b0; #1;
    checks++;
    if (all_outs() !== 17'd0) begin
      errors++; $display("FAIL reset_mid_stream: got %h expected 00000", all_outs());
    end
    pvalid_i = 1'b0; core_rdy_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick(); #1;
      if (cvalid_o || done_o || busy_o) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_quiet: %0d cycles with cvalid/done/busy expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_start_ignored();
    test_back_to_back();
    test_gap();
    test_timeout();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
